spi_pwm_slave: RTL and testbench
================================

// Module: spi_pwm_slave
// PURPOSE
//  Parametrised SPI slave (mode 0) driving N_CH PWM LED channels from a register map.
//  Sits between the PMOD JA pins (sclk/cs/mosi/miso) and the PMOD JE LED outputs.
//  All logic runs on sysclk; SPI inputs are oversampled, so no SPI-clock domain exists.
//  Frame: 16 bits, MSB first; byte0 = {RW, ADDR[6:0]} (RW=1 read), byte1 = data.
// PARAMETERS
//  N_CH        8      number of PWM/LED channels, 1..64; duty regs at ADDR 0..N_CH-1
//  PRESCALE    4      sysclk cycles per PWM counter tick, >=1
//  SYNC_STAGES 2      synchroniser depth on sclk/cs/mosi, >=2
//  ID_VALUE    8'hA5  constant returned by read of ADDR 0x7F
// PORTS
//  sysclk  in   1     system clock; sclk must be <= sysclk/8
//  rst     in   1     asynchronous, active-high reset
//  sclk    in   1     SPI clock, idle low
//  cs      in   1     SPI chip select, active low
//  mosi    in   1     master-out data
//  miso    out  1     slave-out data, registered
//  led     out  N_CH  PWM outputs, led[i] = channel i
// BEHAVIOUR
//  Reset: miso=0, led=0, all duty (shadow+active)=0, CTRL=8'h01, PWM counter=0, frame idle.
//  Inputs pass SYNC_STAGES flops; edges detected on synchronised sclk (rise/fall pulses).
//  Frame FSM: IDLE -> CMD (cs falls) -> DATA (8th rise) -> DONE (16th rise) -> IDLE (cs rises).
//   - mosi sampled on sclk rise; miso updated on sclk fall only.
//   - CMD: 8 bits into cmd reg. At 8th rise: if RW=1, load tx reg with register value,
//     drive tx[7] on miso at the next sclk fall, shift on each following fall.
//   - DATA: 8 bits into data reg. At 16th rise with RW=0: commit write (1 sysclk later).
//   - DONE: further sclk edges ignored; miso held 0.
//   - cs rises before 16th rise: frame aborted, no write, FSM -> IDLE. cs high: miso=0.
//   - cs falls while in DONE/abort: only after returning to IDLE (cs must be seen high).
//  Register map (8-bit):
//   0..N_CH-1  DUTY[i]  RW  shadow duty of channel i
//   0x40       CTRL     RW  bit0 global enable, bit1 output invert, bits7:2 read 0
//   0x7F       ID       RO  ID_VALUE; writes ignored
//   other      --       reads 0x00, writes ignored
//  PWM: 8-bit counter, +1 every PRESCALE sysclk, wraps 255->0 (period 256*PRESCALE).
//   - active duty updated from shadow only on the wrap tick (glitch-free).
//   - raw[i] = (cnt < active[i]); duty 0 -> always off, 255 -> 255/256 on.
//   - led[i] = CTRL.en ? raw[i]^CTRL.inv : 0 (registered, 1 sysclk after counter).
//   - CTRL changes take effect immediately (no wrap alignment).
//  Write and wrap in same cycle: write lands in shadow; wrap takes the old shadow.
//  Reset mid-frame or mid-period: all state returns to reset values at once.
// CONFIGURATION
//  SPI_PWM_FADE_EN defined: on each wrap, active[i] moves 1 LSB toward shadow[i]
//   (no change if equal); full 0->255 ramp takes 255 PWM periods.
//  Not defined: on each wrap, active[i] = shadow[i] directly.
//  Register map and SPI behaviour identical in both builds.
// TESTING
//  1 Reset then read ADDR 0x7F -> miso returns 8'hA5 in byte1; led all 0.
//  2 Write DUTY[2]=8'h40, no fade -> from next wrap led[2] high 64 of 256 ticks.
//  3 Write DUTY[0]=8'hFF, read back ADDR 0x00 -> 8'hFF; write ADDR 0x7F=8'h00, read -> 8'hA5.
//  4 cs rises after 11 bits of write DUTY[1]=8'h80 -> DUTY[1] stays 0, next full frame OK.
//  5 CTRL=8'h03 with DUTY[3]=0 -> led[3] constantly 1; CTRL=8'h00 -> all led 0.
//  6 SPI_PWM_FADE_EN, DUTY[4] 0->8'h04 -> active duty 1,2,3,4 on 4 successive wraps.

Source files
------------

// File: rtl/spi_pwm_slave.sv
// rtl/spi_pwm_slave.sv - oversampled SPI mode-0 slave with a register-mapped N_CH PWM LED bank
// Optional build macro SPI_PWM_FADE_EN: active duty ramps 1 LSB per PWM period toward shadow.
module spi_pwm_slave #(
    parameter int N_CH        = 8,
    parameter int PRESCALE    = 4,
    parameter int SYNC_STAGES = 2,
    parameter logic [7:0] ID_VALUE = 8'hA5
) (
    input  logic            sysclk,
    input  logic            rst,
    input  logic            sclk,
    input  logic            cs,
    input  logic            mosi,
    output logic            miso,
    output logic [N_CH-1:0] led
);
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    typedef enum logic [1:0] {IDLE, CMD, DATA, DONE} state_t;
    state_t state, state_nxt;

    logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
    logic       sclk_s, cs_s, mosi_s, sclk_d, rise, fall;
    logic [3:0] bit_cnt;
    logic [7:0] cmd, data, tx, rd_val;
    logic [6:0] rd_addr, wr_addr;
    logic [7:0] wr_data;
    logic       wr_en;
    logic [1:0] ctrl;
    logic [7:0] shadow [N_CH];
    logic [7:0] active [N_CH];
    logic [PW-1:0] pre_cnt;
    logic [7:0] cnt;
    logic       tick, wrap;
    logic [N_CH-1:0] raw;

    // cs synchroniser resets to deselected so the FSM does not start a frame out of reset
    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            sclk_sync <= '0;
            cs_sync   <= '1;
            mosi_sync <= '0;
            sclk_d    <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            sclk_d    <= sclk_s;
        end
    end

    assign sclk_s  = sclk_sync[SYNC_STAGES-1];
    assign cs_s    = cs_sync[SYNC_STAGES-1];
    assign mosi_s  = mosi_sync[SYNC_STAGES-1];
    assign rise    = sclk_s & ~sclk_d & ~cs_s;
    assign fall    = ~sclk_s & sclk_d & ~cs_s;
    assign rd_addr = {cmd[5:0], mosi_s};

    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (!cs_s) state_nxt = CMD;
            CMD:  if (cs_s) state_nxt = IDLE;
                  else if (rise && bit_cnt == 4'd7) state_nxt = DATA;
            DATA: if (cs_s) state_nxt = IDLE;
                  else if (rise && bit_cnt == 4'd15) state_nxt = DONE;
            DONE: if (cs_s) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        rd_val = 8'h00;
        for (int i = 0; i < N_CH; i++)
            if (rd_addr == 7'(i)) rd_val = shadow[i];
        if (rd_addr == 7'h40) rd_val = {6'b0, ctrl};
        if (rd_addr == 7'h7F) rd_val = ID_VALUE;
    end

    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            bit_cnt <= '0;
            cmd     <= '0;
            data    <= '0;
            tx      <= '0;
            miso    <= 1'b0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            wr_en <= 1'b0;
            case (state)
                IDLE: begin
                    bit_cnt <= '0;
                    miso    <= 1'b0;
                end
                CMD: if (rise) begin
                    cmd     <= {cmd[6:0], mosi_s};
                    bit_cnt <= bit_cnt + 4'd1;
                    if (bit_cnt == 4'd7 && cmd[6]) tx <= rd_val;
                end
                DATA: begin
                    if (rise) begin
                        data    <= {data[6:0], mosi_s};
                        bit_cnt <= bit_cnt + 4'd1;
                        if (bit_cnt == 4'd15 && !cmd[7]) begin
                            wr_en   <= 1'b1;
                            wr_addr <= cmd[6:0];
                            wr_data <= {data[6:0], mosi_s};
                        end
                    end
                    if (fall && cmd[7]) begin
                        miso <= tx[7];
                        tx   <= {tx[6:0], 1'b0};
                    end
                end
                default: miso <= 1'b0;
            endcase
            if (cs_s) miso <= 1'b0;
        end
    end

    assign tick = (pre_cnt == PW'(PRESCALE - 1));
    assign wrap = tick && (cnt == 8'hFF);

    // Same-cycle write and wrap: wrap samples the pre-write shadow via nonblocking semantics
    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            ctrl    <= 2'b01;
            pre_cnt <= '0;
            cnt     <= '0;
            for (int i = 0; i < N_CH; i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
            end
        end else begin
            pre_cnt <= tick ? '0 : pre_cnt + PW'(1);
            if (tick) cnt <= cnt + 8'd1;
            if (wr_en && wr_addr == 7'h40) ctrl <= wr_data[1:0];
            for (int i = 0; i < N_CH; i++) begin
                if (wr_en && wr_addr == 7'(i)) shadow[i] <= wr_data;
`ifdef SPI_PWM_FADE_EN
                if (wrap && active[i] < shadow[i]) active[i] <= active[i] + 8'd1;
                else if (wrap && active[i] > shadow[i]) active[i] <= active[i] - 8'd1;
`else
                if (wrap) active[i] <= shadow[i];
`endif
            end
        end
    end

    always_comb begin
        raw = '0;
        for (int i = 0; i < N_CH; i++) raw[i] = (cnt < active[i]);
    end

    always_ff @(posedge sysclk or posedge rst) begin
        if (rst)          led <= '0;
        else if (ctrl[0]) led <= raw ^ {N_CH{ctrl[1]}};
        else              led <= '0;
    end
endmodule

// File: tb/tb_spi_pwm_slave.sv
// tb/tb_spi_pwm_slave.sv - directed self-checking bench for spi_pwm_slave
module tb_spi_pwm_slave;
    localparam int T    = 10;
    localparam int HALF = 80;

    logic       sysclk = 1'b0;
    logic       rst = 1'b1;
    logic       sclk = 1'b0;
    logic       cs = 1'b1;
    logic       mosi = 1'b0;
    logic       miso;
    logic [7:0] led;
    logic [7:0] rx;
    int         errors = 0;
    int         checks = 0;
    int         n;

    spi_pwm_slave dut (
        .sysclk(sysclk), .rst(rst), .sclk(sclk), .cs(cs),
        .mosi(mosi), .miso(miso), .led(led)
    );

    always #(T/2) sysclk = ~sysclk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic spi_xfer(input logic [15:0] frame, input int nbits, output logic [7:0] r);
        r = 8'h00;
        cs = 1'b0;
        #(HALF);
        for (int i = 0; i < nbits; i++) begin
            mosi = frame[15-i];
            #(HALF);
            if (i >= 8) r[15-i] = miso;
            sclk = 1'b1;
            #(HALF);
            sclk = 1'b0;
        end
        #(HALF);
        cs = 1'b1;
        mosi = 1'b0;
        #(2*HALF);
    endtask

    task automatic wr(input logic [6:0] a, input logic [7:0] d);
        logic [7:0] dummy;
        spi_xfer({1'b0, a, d}, 16, dummy);
    endtask

    task automatic rd(input logic [6:0] a, output logic [7:0] d);
        spi_xfer({1'b1, a, 8'h00}, 16, d);
    endtask

    // count sysclk samples (negedge) over nc cycles where led[ch] is high
    task automatic count_high(input int ch, input int nc, output int c);
        c = 0;
        for (int i = 0; i < nc; i++) begin
            @(negedge sysclk);
            if (led[ch]) c++;
        end
    endtask

    initial begin
        repeat (5) @(negedge sysclk);
        chk("reset_miso", miso, 0);
        chk("reset_led", led, 0);
        rst = 1'b0;
        repeat (5) @(negedge sysclk);

        rd(7'h7F, rx);           chk("read_id", rx, 8'hA5);
        chk("led_idle", led, 0);
        rd(7'h40, rx);           chk("read_ctrl_reset", rx, 8'h01);
        rd(7'h02, rx);           chk("read_duty2_reset", rx, 8'h00);

        wr(7'h02, 8'h40);
        wr(7'h00, 8'hFF);
        rd(7'h00, rx);           chk("read_duty0", rx, 8'hFF);
        rd(7'h02, rx);           chk("read_duty2", rx, 8'h40);
        wr(7'h7F, 8'h00);
        rd(7'h7F, rx);           chk("id_readonly", rx, 8'hA5);
        wr(7'h50, 8'hAA);
        rd(7'h50, rx);           chk("unmapped_read", rx, 8'h00);

        spi_xfer({1'b0, 7'h01, 8'h80}, 11, rx);
        rd(7'h01, rx);           chk("abort_no_write", rx, 8'h00);
        wr(7'h01, 8'h80);
        rd(7'h01, rx);           chk("write_after_abort", rx, 8'h80);

`ifndef SPI_PWM_FADE_EN
        repeat (2100) @(negedge sysclk);
        count_high(2, 1024, n);  chk("pwm_duty40", n, 256);
        count_high(0, 1024, n);  chk("pwm_dutyFF", n, 1020);
        count_high(1, 1024, n);  chk("pwm_duty80", n, 512);
        count_high(5, 1024, n);  chk("pwm_duty00", n, 0);

        wr(7'h40, 8'hFF);
        rd(7'h40, rx);           chk("ctrl_mask", rx, 8'h03);
        count_high(3, 1024, n);  chk("inv_duty0_on", n, 1024);
        count_high(2, 1024, n);  chk("inv_duty40", n, 768);
        wr(7'h40, 8'h00);
        n = 0;
        for (int i = 0; i < 1024; i++) begin
            @(negedge sysclk);
            if (led != 8'h00) n++;
        end
        chk("disable_all_off", n, 0);
`endif

        #(37);
        rst = 1'b1;
        #(3);
        chk("midrun_reset_led", led, 0);
        chk("midrun_reset_miso", miso, 0);
        @(negedge sysclk);
        rst = 1'b0;
        repeat (3) @(negedge sysclk);
        rd(7'h00, rx);           chk("reset_duty0", rx, 8'h00);
        rd(7'h40, rx);           chk("reset_ctrl", rx, 8'h01);

`ifdef SPI_PWM_FADE_EN
        wr(7'h04, 8'h04);
        n = 0;
        for (int i = 0; i < 3000 && !led[4]; i++) @(negedge sysclk);
        chk("fade_start", led[4], 1);
        for (int k = 1; k <= 4; k++) begin
            count_high(4, 1024, n);
            chk("fade_step", n, 4 * k);
        end
        count_high(4, 1024, n);  chk("fade_hold", n, 16);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
